fp16_align: RTL and testbench

FP16_ALIGN -- requirements
Module: fp16_align

---
 rtl/fp16_pkg.sv | 31 +++
 rtl/fp16_align_if.sv | 40 ++++
 rtl/fp16_unpack.sv | 34 +++
 rtl/fp16_align.sv | 130 +++++++++++++
 tb/tb_fp16_align.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 constants, operand struct and alignment FSM states.
// Consumed by fp16_unpack and fp16_align via import fp16_pkg::*.
package fp16_pkg;

  localparam int EXP_W     = 5;
  localparam int FRAC_W    = 10;
  localparam int MANT_W    = 11;
  localparam int MAX_SHIFT = 13;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } align_state_t;

  function automatic logic [MANT_W-1:0] sig_of(fp16_t x);
    return {|x.exp, x.frac};
  endfunction

  // Subnormals share exponent 1 with the smallest normals.
  function automatic logic [EXP_W-1:0] eff_exp(fp16_t x);
    return (x.exp == '0) ? EXP_W'(1) : x.exp;
  endfunction

endpackage

// File: rtl/fp16_align_if.sv
// Operand/result handshake bundle for fp16_align.
// grs exists only when FP16_ALIGN_STICKY_EN is defined.
interface fp16_align_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] mant_big;
  logic [10:0] mant_small;
  logic [4:0]  exp_out;
  logic        sign_out;
  logic        sum_add;
  logic        special;
`ifdef FP16_ALIGN_STICKY_EN
  logic [2:0]  grs;
`endif

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, mant_big, mant_small,
    input  exp_out, sign_out, sum_add, special
`ifdef FP16_ALIGN_STICKY_EN
    , input grs
`endif
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, mant_big, mant_small,
    output exp_out, sign_out, sum_add, special
`ifdef FP16_ALIGN_STICKY_EN
    , output grs
`endif
  );

endinterface

// File: rtl/fp16_unpack.sv
// Combinational unpack, magnitude compare and big/small swap
// of two binary16 operands ahead of exponent alignment.
module fp16_unpack
  import fp16_pkg::*;
(
  input  fp16_t             a,
  input  fp16_t             b,
  input  logic              sub,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic [EXP_W-1:0]  exp_big,
  output logic [EXP_W-1:0]  diff,
  output logic              sign,
  output logic              sum_add,
  output logic              special
);

  logic             a_big;
  logic [EXP_W-1:0] exp_small;

  // Ties keep A as the big operand.
  assign a_big = {a.exp, a.frac} >= {b.exp, b.frac};

  assign mant_big   = a_big ? sig_of(a) : sig_of(b);
  assign mant_small = a_big ? sig_of(b) : sig_of(a);
  assign exp_big    = a_big ? eff_exp(a) : eff_exp(b);
  assign exp_small  = a_big ? eff_exp(b) : eff_exp(a);
  assign diff       = exp_big - exp_small;

  assign sign    = a_big ? a.sign : (b.sign ^ sub);
  assign sum_add = a.sign ^ b.sign ^ sub;
  assign special = (&a.exp) | (&b.exp);

endmodule

// File: rtl/fp16_align.sv
// FP16 exponent alignment: serial right shifter under an IDLE/SHIFT/DONE FSM.
// Define FP16_ALIGN_STICKY_EN to keep guard/round/sticky bits on grs.
module fp16_align #(
  parameter int MANT_W    = 11,
  parameter int MAX_SHIFT = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  fp16_align_if.slave  io
);

  import fp16_pkg::*;

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);

  fp16_t               a;
  fp16_t               b;
  logic [MANT_W-1:0]   u_big;
  logic [MANT_W-1:0]   u_small;
  logic [EXP_W-1:0]    u_exp;
  logic [EXP_W-1:0]    u_diff;
  logic                u_sign;
  logic                u_sum_add;
  logic                u_special;
  logic [CNT_W-1:0]    cnt_in;

  align_state_t        state_q;
  align_state_t        state_d;
  logic                take;

  logic [MANT_W-1:0]   big_q;
  logic [MANT_W-1:0]   small_q;
  logic [EXP_W-1:0]    exp_q;
  logic                sign_q;
  logic                sum_add_q;
  logic                special_q;
  logic [CNT_W-1:0]    cnt_q;
`ifdef FP16_ALIGN_STICKY_EN
  logic [2:0]          grs_q;
`endif

  assign a = io.op_a;
  assign b = io.op_b;

  fp16_unpack u_unpack (
    .a          (a),
    .b          (b),
    .sub        (io.sub),
    .mant_big   (u_big),
    .mant_small (u_small),
    .exp_big    (u_exp),
    .diff       (u_diff),
    .sign       (u_sign),
    .sum_add    (u_sum_add),
    .special    (u_special)
  );

  assign cnt_in = (u_diff > EXP_W'(MAX_SHIFT))
                ? CNT_W'(MAX_SHIFT)
                : CNT_W'(u_diff);

  assign take = (state_q == IDLE) && io.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (io.in_valid)
          state_d = (u_special || cnt_in == '0) ? DONE : SHIFT;
      end
      (state_q == SHIFT): begin
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      (state_q == DONE): begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      big_q     <= '0;
      small_q   <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      sum_add_q <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
`ifdef FP16_ALIGN_STICKY_EN
      grs_q     <= '0;
`endif
    end else if (take) begin
      big_q     <= u_big;
      small_q   <= u_small;
      exp_q     <= u_exp;
      sign_q    <= u_sign;
      sum_add_q <= u_sum_add;
      special_q <= u_special;
      cnt_q     <= u_special ? '0 : cnt_in;
`ifdef FP16_ALIGN_STICKY_EN
      grs_q     <= '0;
`endif
    end else if (state_q == SHIFT) begin
      small_q <= small_q >> 1;
      cnt_q   <= cnt_q - CNT_W'(1);
`ifdef FP16_ALIGN_STICKY_EN
      grs_q   <= {small_q[0], grs_q[2], grs_q[1] | grs_q[0]};
`endif
    end
  end

  assign io.in_ready   = (state_q == IDLE);
  assign io.out_valid  = (state_q == DONE);
  assign io.mant_big   = big_q;
  assign io.mant_small = small_q;
  assign io.exp_out    = exp_q;
  assign io.sign_out   = sign_q;
  assign io.sum_add    = sum_add_q;
  assign io.special    = special_q;
`ifdef FP16_ALIGN_STICKY_EN
  assign io.grs        = grs_q;
`endif

endmodule

// File: tb/tb_fp16_align.sv
// Directed and random stimulus for fp16_align against an arithmetic
// reference model of binary16 alignment.
module tb_fp16_align;

  logic clk;
  logic rst_n;
  int   cmps;
  int   errs;

  fp16_align_if bus ();

  fp16_align dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mb;
    int ms;
    int e;
    int sg;
    int sa;
    int sp;
    int grs;
    int lat;
  } exp_t;

  function automatic exp_t model(logic [15:0] a, logic [15:0] b,
                                 logic s);
    exp_t r;
    logic [15:0] bg;
    logic [15:0] sm;
    int eb, es, sb, ss, n, g, rr, st;
    if (a[14:0] >= b[14:0]) begin
      bg = a; sm = b; r.sg = int'(a[15]);
    end else begin
      bg = b; sm = a; r.sg = int'(b[15] ^ s);
    end
    r.sa = int'(a[15] ^ b[15] ^ s);
    r.sp = int'(a[14:10] == 5'd31 || b[14:10] == 5'd31);
    eb = (bg[14:10] == 0) ? 1 : int'(bg[14:10]);
    es = (sm[14:10] == 0) ? 1 : int'(sm[14:10]);
    sb = ((bg[14:10] != 0) ? 1024 : 0) + int'(bg[9:0]);
    ss = ((sm[14:10] != 0) ? 1024 : 0) + int'(sm[9:0]);
    n = eb - es;
    if (n > 13) n = 13;
    if (r.sp != 0) n = 0;
    r.mb = sb;
    r.e  = eb;
    r.ms = ss / (1 << n);
    g  = (n >= 1) ? (ss >> (n - 1)) & 1 : 0;
    rr = (n >= 2) ? (ss >> (n - 2)) & 1 : 0;
    st = (n >= 3) ? int'((ss % (1 << (n - 2))) != 0) : 0;
    r.grs = g * 4 + rr * 2 + st;
    r.lat = n + 1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    cmps++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input exp_t m);
    chk("mant_big",   32'(bus.mant_big),   32'(m.mb));
    chk("mant_small", 32'(bus.mant_small), 32'(m.ms));
    chk("exp_out",    32'(bus.exp_out),    32'(m.e));
    chk("sign_out",   32'(bus.sign_out),   32'(m.sg));
    chk("sum_add",    32'(bus.sum_add),    32'(m.sa));
    chk("special",    32'(bus.special),    32'(m.sp));
`ifdef FP16_ALIGN_STICKY_EN
    chk("grs",        32'(bus.grs),        32'(m.grs));
`endif
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic s);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.op_a = a;
    bus.op_b = b;
    bus.sub = s;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a = 16'($urandom);
    bus.op_b = 16'($urandom);
    bus.sub = 1'($urandom);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input int stall, input bit tog);
    exp_t m;
    int lat;
    m = model(a, b, s);
    issue(a, b, s);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(m.lat));
    check_out(m);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = tog ? ~bus.in_valid : 1'b0;
      @(posedge clk); #1;
      chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check_out(m);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_in_ready",  32'(bus.in_ready),  32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    cmps = 0;
    errs = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_mant_big",  32'(bus.mant_big),  32'd0);
    chk("rst_exp_out",   32'(bus.exp_out),   32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    do_op(16'h3C00, 16'h3C00, 1'b0, 0, 1'b0);
    do_op(16'h3C00, 16'hBC00, 1'b0, 0, 1'b0);
    do_op(16'h3C00, 16'h4000, 1'b0, 1, 1'b0);
    do_op(16'h6400, 16'h3C01, 1'b0, 0, 1'b0);
    do_op(16'h7800, 16'h0001, 1'b1, 0, 1'b0);
    do_op(16'h7C00, 16'h3C00, 1'b0, 0, 1'b0);
    do_op(16'h3555, 16'h7E01, 1'b1, 0, 1'b0);
    do_op(16'h0003, 16'h8005, 1'b0, 0, 1'b0);
    do_op(16'h4A3F, 16'hC21D, 1'b0, 5, 1'b1);
    do_op(16'h3C00, 16'h4000, 1'b1, 0, 1'b0);

    issue(16'h6400, 16'h3C01, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid",  32'(bus.out_valid),  32'd0);
    chk("midrst_in_ready",   32'(bus.in_ready),   32'd1);
    chk("midrst_mant_small", 32'(bus.mant_small), 32'd0);
    chk("midrst_mant_big",   32'(bus.mant_big),   32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
    do_op(16'h3C00, 16'h3C00, 1'b0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) rb[14:10] = ra[14:10] - 5'($urandom_range(0, 4));
      if (i % 11 == 0) ra[14:10] = 5'd31;
      if (i % 7 == 0) rb[14:10] = 5'd0;
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmps, errs);
    $finish;
  end

endmodule
